cdb_arbiter: RTL and testbench

Common-data-bus arbiter between the execution units and the reorder buffer. The ALU and the load/store buffer each push results into a small per-source FIFO. The arbiter grants one result per cycle onto a single registered broadcast bus, which the ROB, reservation station and LSB all snoop. This reduces the ROB/RS result-write ports from two to one and decouples unit completion from bus availability.

---
 rtl/cdb_pkg.sv | 36 +++
 rtl/cdb_fifo.sv | 62 ++++++
 rtl/cdb_arbiter.sv | 119 +++++++++++
 tb/tb_cdb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: source encodings, payload
// layouts and the arbitration pick helper.
package cdb_arbiter_pkg;

   localparam logic CDB_SRC_ALU    = 1'b0;
   localparam logic CDB_SRC_LSB    = 1'b1;
   localparam int   CDB_FIFO_DEPTH = 2;
   localparam int   ROB_ID_W       = 5;

   typedef struct packed {
      logic [31:0]         res;
      logic [ROB_ID_W-1:0] rob_id;
      logic                jump_choice;
      logic [31:0]         pc;
   } alu_pkt_t;

   typedef struct packed {
      logic [31:0]         res;
      logic [ROB_ID_W-1:0] rob_id;
   } lsb_pkt_t;

   // Contention is resolved by prefer_lsb; a lone pending source always wins.
   function automatic logic pick_src(input logic alu_pend, input logic lsb_pend,
                                     input logic prefer_lsb);
      logic src;
      if (alu_pend && lsb_pend) begin
         src = prefer_lsb ? CDB_SRC_LSB : CDB_SRC_ALU;
      end else if (lsb_pend) begin
         src = CDB_SRC_LSB;
      end else begin
         src = CDB_SRC_ALU;
      end
      return src;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO with flush, used once per result source in front of
// the common data bus. Depth must be a power of two so pointers wrap naturally.
module cdb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   assign empty  = (count_r == CNT_W'(0));
   assign full   = (count_r == CNT_W'(DEPTH));
   assign push_s = push && !full && !flush;
   assign pop_s  = pop && !empty && !flush;
   assign dout   = mem_r[rd_ptr_r];

   // Pointer and occupancy tracking; flush empties the FIFO synchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         else        wr_ptr_r <= wr_ptr_r;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         else        rd_ptr_r <= rd_ptr_r;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: ALU and LSB results queue in per-source FIFOs and one
// is broadcast per cycle. Define CDB_RR_EN for round-robin, else LSB has priority.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                flush,
   input  logic                alu_valid,
   input  logic [31:0]         alu_res,
   input  logic [ROB_ID_W-1:0] alu_rob_id,
   input  logic                alu_jump_choice,
   input  logic [31:0]         alu_pc,
   output logic                alu_ready,
   input  logic                lsb_valid,
   input  logic [31:0]         lsb_res,
   input  logic [ROB_ID_W-1:0] lsb_rob_id,
   output logic                lsb_ready,
   output logic                cdb_valid,
   output logic                cdb_src,
   output logic [31:0]         cdb_res,
   output logic [ROB_ID_W-1:0] cdb_rob_id,
   output logic                cdb_jump_choice,
   output logic [31:0]         cdb_pc
);

   alu_pkt_t alu_din_s, alu_dout_s;
   lsb_pkt_t lsb_din_s, lsb_dout_s;
   logic     alu_empty_s, alu_full_s, lsb_empty_s, lsb_full_s;
   logic     alu_push_s, lsb_push_s, alu_pop_s, lsb_pop_s;
   logic     grant_vld_s, grant_src_s, prefer_lsb_s;

   // Readiness looks only at registered occupancy, never at a same-cycle pop.
   assign alu_ready  = rdy && !alu_full_s;
   assign lsb_ready  = rdy && !lsb_full_s;
   assign alu_push_s = alu_valid && alu_ready && !flush;
   assign lsb_push_s = lsb_valid && lsb_ready && !flush;
   assign alu_din_s  = '{res: alu_res, rob_id: alu_rob_id,
                         jump_choice: alu_jump_choice, pc: alu_pc};
   assign lsb_din_s  = '{res: lsb_res, rob_id: lsb_rob_id};

   cdb_fifo #(.WIDTH($bits(alu_pkt_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk(clk), .rst(rst), .flush(flush), .push(alu_push_s), .pop(alu_pop_s),
      .din(alu_din_s), .dout(alu_dout_s), .empty(alu_empty_s), .full(alu_full_s)
   );

   cdb_fifo #(.WIDTH($bits(lsb_pkt_t)), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
      .clk(clk), .rst(rst), .flush(flush), .push(lsb_push_s), .pop(lsb_pop_s),
      .din(lsb_din_s), .dout(lsb_dout_s), .empty(lsb_empty_s), .full(lsb_full_s)
   );

`ifdef CDB_RR_EN
   logic last_grant_r;

   // Remembers the most recent winner so the other source wins the next tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_r <= CDB_SRC_ALU;
      end else if (flush) begin
         last_grant_r <= CDB_SRC_ALU;
      end else if (grant_vld_s) begin
         last_grant_r <= grant_src_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   assign prefer_lsb_s = (last_grant_r == CDB_SRC_ALU);
`else
   assign prefer_lsb_s = 1'b1;
`endif

   // Grant decision from registered FIFO state.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_src_s = CDB_SRC_ALU;
      if (rdy && !flush && (!alu_empty_s || !lsb_empty_s)) begin
         grant_vld_s = 1'b1;
         grant_src_s = pick_src(!alu_empty_s, !lsb_empty_s, prefer_lsb_s);
      end else begin
         grant_vld_s = 1'b0;
      end
   end

   assign alu_pop_s = grant_vld_s && (grant_src_s == CDB_SRC_ALU);
   assign lsb_pop_s = grant_vld_s && (grant_src_s == CDB_SRC_LSB);

   // Broadcast register; payload holds whenever nothing is granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid       <= 1'b0;
         cdb_src         <= CDB_SRC_ALU;
         cdb_res         <= 32'd0;
         cdb_rob_id      <= '0;
         cdb_jump_choice <= 1'b0;
         cdb_pc          <= 32'd0;
      end else if (grant_vld_s && (grant_src_s == CDB_SRC_LSB)) begin
         cdb_valid       <= 1'b1;
         cdb_src         <= CDB_SRC_LSB;
         cdb_res         <= lsb_dout_s.res;
         cdb_rob_id      <= lsb_dout_s.rob_id;
         cdb_jump_choice <= 1'b0;
         cdb_pc          <= 32'd0;
      end else if (grant_vld_s) begin
         cdb_valid       <= 1'b1;
         cdb_src         <= CDB_SRC_ALU;
         cdb_res         <= alu_dout_s.res;
         cdb_rob_id      <= alu_dout_s.rob_id;
         cdb_jump_choice <= alu_dout_s.jump_choice;
         cdb_pc          <= alu_dout_s.pc;
      end else begin
         cdb_valid       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, a sustained
// contention sequence, random traffic against a queue model, and async reset.
module tb_cdb_arbiter;

   localparam int DEPTH = 2;

   typedef struct {
      logic        rdy, flush;
      logic        av;
      logic [31:0] ares;
      logic [4:0]  aid;
      logic        aj;
      logic [31:0] apc;
      logic        lv;
      logic [31:0] lres;
      logic [4:0]  lid;
      logic        e_ar, e_lr, e_valid, e_src;
      logic [4:0]  e_id;
      logic [31:0] e_res;
      logic        e_j;
      logic [31:0] e_pc;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  id;
      logic        j;
      logic [31:0] pc;
   } ent_t;

   logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, flush = 1'b0;
   logic        alu_valid = 1'b0, alu_jump_choice = 1'b0, lsb_valid = 1'b0;
   logic [31:0] alu_res = 32'd0, alu_pc = 32'd0, lsb_res = 32'd0;
   logic [4:0]  alu_rob_id = 5'd0, lsb_rob_id = 5'd0;
   logic        alu_ready, lsb_ready, cdb_valid, cdb_src, cdb_jump_choice;
   logic [31:0] cdb_res, cdb_pc;
   logic [4:0]  cdb_rob_id;

   int n_cmp = 0;
   int n_err = 0;

   ent_t aq[$];
   ent_t lq[$];
   bit   m_lg;
   logic m_valid, m_src, m_j;
   logic [4:0]  m_id;
   logic [31:0] m_res, m_pc;

   vec_t tbl[20];

   cdb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .alu_valid(alu_valid), .alu_res(alu_res), .alu_rob_id(alu_rob_id),
      .alu_jump_choice(alu_jump_choice), .alu_pc(alu_pc), .alu_ready(alu_ready),
      .lsb_valid(lsb_valid), .lsb_res(lsb_res), .lsb_rob_id(lsb_rob_id),
      .lsb_ready(lsb_ready), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
      .cdb_res(cdb_res), .cdb_rob_id(cdb_rob_id),
      .cdb_jump_choice(cdb_jump_choice), .cdb_pc(cdb_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic f, input logic av,
                               input logic [31:0] ares, input logic [4:0] aid,
                               input logic aj, input logic [31:0] apc, input logic lv,
                               input logic [31:0] lres, input logic [4:0] lid,
                               input logic ear, input logic elr, input logic ev,
                               input logic es, input logic [4:0] eid,
                               input logic [31:0] eres, input logic ej,
                               input logic [31:0] epc);
      vec_t v;
      v.rdy = r; v.flush = f; v.av = av; v.ares = ares; v.aid = aid; v.aj = aj;
      v.apc = apc; v.lv = lv; v.lres = lres; v.lid = lid; v.e_ar = ear;
      v.e_lr = elr; v.e_valid = ev; v.e_src = es; v.e_id = eid; v.e_res = eres;
      v.e_j = ej; v.e_pc = epc;
      return v;
   endfunction

   function automatic vec_t idle(input logic r, input logic ear, input logic elr,
                                 input logic ev, input logic es, input logic [4:0] eid,
                                 input logic [31:0] eres, input logic ej,
                                 input logic [31:0] epc);
      return mk(r, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0,
                ear, elr, ev, es, eid, eres, ej, epc);
   endfunction

   task automatic model_reset();
      aq.delete();
      lq.delete();
      m_lg = 1'b0;
      m_valid = 1'b0; m_src = 1'b0; m_j = 1'b0;
      m_id = 5'd0; m_res = 32'd0; m_pc = 32'd0;
   endtask

   // Reference: one clock edge of the arbiter, written from the behavioural rules.
   task automatic model_edge(input vec_t v, input bit ar, input bit lr);
      ent_t e;
      int   pick;
      if (v.flush) begin
         aq.delete(); lq.delete(); m_lg = 1'b0; m_valid = 1'b0;
      end else if (!v.rdy) begin
         m_valid = 1'b0;
      end else begin
         pick = -1;
         if (aq.size() > 0 && lq.size() > 0) begin
`ifdef CDB_RR_EN
            pick = (m_lg == 1'b1) ? 0 : 1;
`else
            pick = 1;
`endif
         end else if (lq.size() > 0) pick = 1;
         else if (aq.size() > 0) pick = 0;
         if (pick == 0) begin
            e = aq.pop_front();
            m_valid = 1'b1; m_src = 1'b0; m_res = e.res; m_id = e.id;
            m_j = e.j; m_pc = e.pc; m_lg = 1'b0;
         end else if (pick == 1) begin
            e = lq.pop_front();
            m_valid = 1'b1; m_src = 1'b1; m_res = e.res; m_id = e.id;
            m_j = 1'b0; m_pc = 32'd0; m_lg = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         if (v.av && ar) begin
            e.res = v.ares; e.id = v.aid; e.j = v.aj; e.pc = v.apc;
            aq.push_back(e);
         end
         if (v.lv && lr) begin
            e.res = v.lres; e.id = v.lid; e.j = 1'b0; e.pc = 32'd0;
            lq.push_back(e);
         end
      end
   endtask

   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      bit ar, lr;
      @(negedge clk);
      rdy = v.rdy; flush = v.flush;
      alu_valid = v.av; alu_res = v.ares; alu_rob_id = v.aid;
      alu_jump_choice = v.aj; alu_pc = v.apc;
      lsb_valid = v.lv; lsb_res = v.lres; lsb_rob_id = v.lid;
      #1;
      ar = v.rdy && (aq.size() < DEPTH);
      lr = v.rdy && (lq.size() < DEPTH);
      chk({tag, " alu_ready"}, 32'(alu_ready), 32'(ar));
      chk({tag, " lsb_ready"}, 32'(lsb_ready), 32'(lr));
      if (use_tbl) begin
         chk({tag, " tbl alu_ready"}, 32'(alu_ready), 32'(v.e_ar));
         chk({tag, " tbl lsb_ready"}, 32'(lsb_ready), 32'(v.e_lr));
      end
      model_edge(v, ar, lr);
      @(posedge clk);
      #1;
      chk({tag, " cdb_valid"}, 32'(cdb_valid), 32'(m_valid));
      chk({tag, " cdb_src"}, 32'(cdb_src), 32'(m_src));
      chk({tag, " cdb_res"}, cdb_res, m_res);
      chk({tag, " cdb_rob_id"}, 32'(cdb_rob_id), 32'(m_id));
      chk({tag, " cdb_jump"}, 32'(cdb_jump_choice), 32'(m_j));
      chk({tag, " cdb_pc"}, cdb_pc, m_pc);
      if (use_tbl) begin
         chk({tag, " tbl cdb_valid"}, 32'(cdb_valid), 32'(v.e_valid));
         if (v.e_valid) begin
            chk({tag, " tbl cdb_src"}, 32'(cdb_src), 32'(v.e_src));
            chk({tag, " tbl cdb_rob_id"}, 32'(cdb_rob_id), 32'(v.e_id));
            chk({tag, " tbl cdb_res"}, cdb_res, v.e_res);
            chk({tag, " tbl cdb_jump"}, 32'(cdb_jump_choice), 32'(v.e_j));
            chk({tag, " tbl cdb_pc"}, cdb_pc, v.e_pc);
         end
      end
   endtask

   initial begin
      vec_t v;
      // Directed vectors; every expectation here holds under either policy.
      tbl[0]  = idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[1]  = mk(1'b1, 1'b0, 1'b1, 32'h1234, 5'd3, 1'b1, 32'h80, 1'b0, 32'd0, 5'd0,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[2]  = idle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h1234, 1'b1, 32'h80);
      tbl[3]  = idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[4]  = mk(1'b1, 1'b0, 1'b1, 32'hA4, 5'd4, 1'b0, 32'h44, 1'b1, 32'hB5, 5'd5,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[5]  = idle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'hB5, 1'b0, 32'd0);
      tbl[6]  = idle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'hA4, 1'b0, 32'h44);
      tbl[7]  = idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[8]  = mk(1'b1, 1'b0, 1'b1, 32'hC6, 5'd6, 1'b1, 32'h66, 1'b1, 32'hD7, 5'd7,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[9]  = idle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[10] = tbl[9];
      tbl[11] = tbl[9];
      tbl[12] = idle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'hD7, 1'b0, 32'd0);
      tbl[13] = idle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 32'hC6, 1'b1, 32'h66);
      tbl[14] = idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[15] = mk(1'b1, 1'b0, 1'b1, 32'hE8, 5'd8, 1'b0, 32'h88, 1'b1, 32'hF9, 5'd9,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[16] = mk(1'b1, 1'b0, 1'b1, 32'hEA, 5'd10, 1'b1, 32'hAA, 1'b1, 32'hFB, 5'd11,
                   1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'hF9, 1'b0, 32'd0);
      tbl[17] = mk(1'b1, 1'b1, 1'b1, 32'hEC, 5'd12, 1'b0, 32'hCC, 1'b0, 32'd0, 5'd0,
                   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[18] = mk(1'b1, 1'b1, 1'b1, 32'hED, 5'd13, 1'b0, 32'hDD, 1'b0, 32'd0, 5'd0,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      tbl[19] = idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

      model_reset();
      #12;
      chk("reset cdb_valid", 32'(cdb_valid), 32'd0);
      chk("reset cdb_res", cdb_res, 32'd0);
      chk("reset cdb_pc", cdb_pc, 32'd0);
      chk("reset alu_ready", 32'(alu_ready), 32'd1);
      chk("reset lsb_ready", 32'(lsb_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // Sustained two-source traffic drives both FIFOs towards full.
      for (int i = 0; i < 8; i++) begin
         v = mk(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 5'(i), 1'b1, 32'h200 + 32'(i),
                1'b1, 32'h300 + 32'(i), 5'(16 + i),
                1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
         step(v, 1'b0, $sformatf("burst%0d", i));
      end
      for (int i = 0; i < 5; i++)
         step(idle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0), 1'b0,
              $sformatf("drain%0d", i));

      for (int i = 0; i < 500; i++) begin
         v = idle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
         v.rdy   = ($urandom_range(0, 9) != 0);
         v.flush = ($urandom_range(0, 39) == 0);
         v.av    = ($urandom_range(0, 9) < 7);
         v.ares  = $urandom;
         v.aid   = 5'($urandom);
         v.aj    = 1'($urandom);
         v.apc   = $urandom;
         v.lv    = ($urandom_range(0, 9) < 7);
         v.lres  = $urandom;
         v.lid   = 5'($urandom);
         step(v, 1'b0, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset with an entry still queued.
      v = mk(1'b1, 1'b0, 1'b1, 32'hAAAA, 5'd1, 1'b1, 32'hBBBB, 1'b1, 32'hCCCC, 5'd2,
             1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
      step(v, 1'b0, "pre_rst0");
      step(idle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0), 1'b0, "pre_rst1");
      #2;
      rst = 1'b0;
      #1;
      chk("async rst cdb_valid", 32'(cdb_valid), 32'd0);
      chk("async rst cdb_res", cdb_res, 32'd0);
      chk("async rst cdb_rob_id", 32'(cdb_rob_id), 32'd0);
      chk("async rst cdb_pc", cdb_pc, 32'd0);
      chk("async rst alu_ready", 32'(alu_ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++)
         step(idle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0), 1'b0,
              $sformatf("post_rst%0d", i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
